// File: rtl/rriot_multi_timer.sv
// Multi-channel RRIOT-style interval timer: per-channel prescaled down-counters
// with sticky underflow flags, interrupt enables, auto-reload and stop control.
module rriot_multi_timer #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned WIDTH    = 8,
    localparam int unsigned CH_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cs,
    input  logic                 we_n,
    input  logic [CH_BITS+3:0]   A,
    input  logic [WIDTH-1:0]     DI,
    output logic [WIDTH-1:0]     DO,
    output logic                 OE,
    output logic [CHANNELS-1:0]  irq_vec,
    output logic                 irq_n
);
    localparam int unsigned PW = 10;

    typedef struct packed {
        logic [WIDTH-1:0] count;
        logic [WIDTH-1:0] reload;
        logic [PW-1:0]    pc;
        logic [PW-1:0]    div;
        logic             flag;
        logic             ie;
        logic             auto_rl;
        logic             stop;
    } chan_t;

    localparam chan_t CH_RST = '{count: '0, reload: '0, pc: '0, div: '0,
                                 flag: 1'b0, ie: 1'b0, auto_rl: 1'b0, stop: 1'b1};

    chan_t                ch_q [CHANNELS];
    chan_t                ch_d [CHANNELS];
    logic [CH_BITS-1:0]   sel;
    logic [3:0]           reg_off;
    logic                 wr;
    logic                 rd;
    logic [CHANNELS-1:0]  hit;
    logic [CHANNELS-1:0]  irq_d;
    logic [WIDTH-1:0]     do_d;
    logic                 oe_d;

    assign sel     = A[CH_BITS+3:4];
    assign reg_off = A[3:0];
    assign wr      = cs & ~we_n;
    assign rd      = cs & we_n;

    // Channel decode; indices at or above CHANNELS match nothing.
    always_comb begin
        hit = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            hit[c] = (sel == CH_BITS'(c));
        end
    end

    // Per-channel next state: read clear, then counting (so a set wins), then writes.
    always_comb begin
        irq_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            ch_d[c] = ch_q[c];

            if (rd && hit[c] && !reg_off[3] && !reg_off[0]) begin
                ch_d[c].flag = 1'b0;
                ch_d[c].ie   = reg_off[2];
            end

            if (!ch_q[c].stop) begin
                if (ch_q[c].pc != ch_q[c].div) begin
                    ch_d[c].pc = ch_q[c].pc + PW'(1);
                end else begin
                    ch_d[c].pc = '0;
                    if (ch_q[c].count != '0) begin
                        ch_d[c].count = ch_q[c].count - WIDTH'(1);
                    end else begin
                        ch_d[c].flag = 1'b1;
                        if (ch_q[c].auto_rl) begin
                            ch_d[c].count = ch_q[c].reload;
                        end else begin
                            ch_d[c].count = '1;
                            ch_d[c].div   = '0;
                        end
                    end
                end
            end

            if (wr && hit[c] && reg_off[3] && !reg_off[0]) begin
                ch_d[c].auto_rl = DI[0];
                ch_d[c].stop    = DI[1];
            end

            if (wr && hit[c] && !reg_off[3]) begin
                ch_d[c].count  = DI;
                ch_d[c].reload = DI;
                ch_d[c].pc     = '0;
                ch_d[c].flag   = 1'b0;
                ch_d[c].ie     = reg_off[2];
                ch_d[c].stop   = 1'b0;
                case (reg_off[1:0])
                    2'd0:    ch_d[c].div = PW'(0);
                    2'd1:    ch_d[c].div = PW'(7);
                    2'd2:    ch_d[c].div = PW'(63);
                    default: ch_d[c].div = PW'(1023);
                endcase
            end

            irq_d[c] = ch_d[c].flag & ch_d[c].ie;
        end
    end

    // Read data mux; unmapped channels read back as zero.
    always_comb begin
        do_d = DO;
        oe_d = 1'b0;
        if (rd) begin
            do_d = '0;
            oe_d = 1'b1;
            for (int c = 0; c < CHANNELS; c++) begin
                if (hit[c]) begin
                    if (reg_off[0]) begin
                        do_d          = '0;
                        do_d[WIDTH-1] = ch_q[c].flag;
                        do_d[1]       = ch_q[c].stop;
                        do_d[0]       = ch_q[c].auto_rl;
                    end else if (reg_off[3]) begin
                        do_d = ch_q[c].reload;
                    end else begin
                        do_d = ch_q[c].count;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                ch_q[c] <= CH_RST;
            end
            DO      <= '0;
            OE      <= 1'b0;
            irq_vec <= '0;
            irq_n   <= 1'b1;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                ch_q[c] <= ch_d[c];
            end
            DO      <= do_d;
            OE      <= oe_d;
            irq_vec <= irq_d;
            irq_n   <= ~|irq_d;
        end
    end

endmodule

// File: tb/tb_rriot_multi_timer.sv
// Self-checking bench for rriot_multi_timer: directed scenarios plus random bus
// traffic, all compared against a cycle-level behavioural model of the timer.
module tb_rriot_multi_timer;
    localparam int unsigned CHANNELS = 2;
    localparam int unsigned WIDTH    = 8;
    localparam int unsigned CH_BITS  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned AW       = CH_BITS + 4;
    localparam int          MAXV     = (1 << WIDTH) - 1;
    localparam int unsigned OW       = WIDTH + CHANNELS + 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                cs = 1'b0;
    logic                we_n = 1'b1;
    logic [AW-1:0]       A = '0;
    logic [WIDTH-1:0]    DI = '0;
    logic [WIDTH-1:0]    DO;
    logic                OE;
    logic [CHANNELS-1:0] irq_vec;
    logic                irq_n;

    always #5 clk = ~clk;

    rriot_multi_timer #(.CHANNELS(CHANNELS), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .cs(cs), .we_n(we_n), .A(A), .DI(DI),
        .DO(DO), .OE(OE), .irq_vec(irq_vec), .irq_n(irq_n)
    );

    int checks = 0;
    int errors = 0;

    // Model: cycles_left counts down to the next prescaler tick.
    int m_count [CHANNELS];
    int m_reload[CHANNELS];
    int m_div   [CHANNELS];
    int m_left  [CHANNELS];
    bit m_flag  [CHANNELS];
    bit m_ie    [CHANNELS];
    bit m_auto  [CHANNELS];
    bit m_stop  [CHANNELS];
    int m_do;
    bit m_oe;

    function automatic int div_of(input logic [1:0] s);
        case (s)
            2'd0:    return 0;
            2'd1:    return 7;
            2'd2:    return 63;
            default: return 1023;
        endcase
    endfunction

    function automatic logic [AW-1:0] addr(input int ch, input logic [3:0] off);
        return {CH_BITS'(ch), off};
    endfunction

    function automatic logic [OW-1:0] exp_out();
        logic [CHANNELS-1:0] iv;
        for (int c = 0; c < CHANNELS; c++) iv[c] = m_flag[c] & m_ie[c];
        return {WIDTH'(m_do), m_oe, iv, ~|iv};
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CHANNELS; c++) begin
            m_count[c] = 0; m_reload[c] = 0; m_div[c] = 0; m_left[c] = 0;
            m_flag[c] = 0; m_ie[c] = 0; m_auto[c] = 0; m_stop[c] = 1;
        end
        m_do = 0;
        m_oe = 0;
    endtask

    task automatic model_edge(input bit c_s, input bit w_n, input int ch,
                              input logic [3:0] off, input int d);
        bit rd;
        bit wr;
        bit uf;
        rd = c_s && w_n;
        wr = c_s && !w_n;
        if (rd) begin
            m_oe = 1;
            if (ch >= CHANNELS) m_do = 0;
            else if (off[0]) m_do = (int'(m_flag[ch]) << (WIDTH - 1)) |
                                    (int'(m_stop[ch]) << 1) | int'(m_auto[ch]);
            else if (off[3]) m_do = m_reload[ch];
            else m_do = m_count[ch];
        end else begin
            m_oe = 0;
        end
        for (int c = 0; c < CHANNELS; c++) begin
            uf = 0;
            if (!m_stop[c]) begin
                if (m_left[c] > 0) begin
                    m_left[c]--;
                end else begin
                    if (m_count[c] > 0) m_count[c]--;
                    else begin
                        uf = 1;
                        if (m_auto[c]) m_count[c] = m_reload[c];
                        else begin m_count[c] = MAXV; m_div[c] = 0; end
                    end
                    m_left[c] = m_div[c];
                end
            end
            if (ch == c) begin
                if (rd && !off[3] && !off[0]) begin m_flag[c] = 0; m_ie[c] = off[2]; end
                if (wr && off[3] && !off[0]) begin m_auto[c] = d[0]; m_stop[c] = d[1]; end
                if (wr && !off[3]) begin
                    m_count[c] = d; m_reload[c] = d; m_div[c] = div_of(off[1:0]);
                    m_left[c] = m_div[c]; m_flag[c] = 0; m_ie[c] = off[2];
                    m_stop[c] = 0; uf = 0;
                end
            end
            if (uf) m_flag[c] = 1;
        end
    endtask

    task automatic step(input bit c_s, input bit w_n, input logic [AW-1:0] a,
                        input logic [WIDTH-1:0] d);
        cs = c_s; we_n = w_n; A = a; DI = d;
        model_edge(c_s, w_n, int'(a[AW-1:4]), a[3:0], int'(d));
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b1, '0, '0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            idle();
            checks++;
            if ({DO, OE, irq_vec, irq_n} !== exp_out()) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: got %h want %h", k, {DO, OE, irq_vec, irq_n}, exp_out());
            end
        end
        for (int c = 0; c < CHANNELS; c++) begin
            step(1'b1, 1'b1, addr(c, 4'b0001), '0);
            checks++;
            if (DO !== WIDTH'(2) || OE !== 1'b1 || irq_n !== 1'b1) begin
                errors++;
                $display("FAIL reset_status ch%0d: got DO=%h OE=%b irq_n=%b want DO=02 OE=1 irq_n=1", c, DO, OE, irq_n);
            end
            step(1'b1, 1'b1, addr(c, 4'b0000), '0);
            checks++;
            if (DO !== '0) begin
                errors++;
                $display("FAIL reset_count ch%0d: got %h want 00", c, DO);
            end
        end
    endtask

    task automatic test_oneshot();
        step(1'b1, 1'b0, addr(0, 4'b0101), WIDTH'(3));
        for (int k = 1; k <= 32; k++) begin
            idle();
            checks++;
            if ({DO, OE, irq_vec, irq_n} !== exp_out()) begin
                errors++;
                $display("FAIL oneshot_model k=%0d: got %h want %h", k, {DO, OE, irq_vec, irq_n}, exp_out());
            end
            if (k == 31) begin
                checks++;
                if (irq_vec[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL oneshot_early: irq_vec[0]=%b want 0 at cycle 31", irq_vec[0]);
                end
            end
        end
        checks++;
        if (irq_vec[0] !== 1'b1 || irq_n !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_fire: irq_vec[0]=%b irq_n=%b want 1/0 at cycle 32", irq_vec[0], irq_n);
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, addr(0, 4'b0100), '0);
            checks++;
            if (DO !== WIDTH'(MAXV - k) || OE !== 1'b1) begin
                errors++;
                $display("FAIL oneshot_freerun k=%0d: got DO=%h OE=%b want %h/1", k, DO, OE, WIDTH'(MAXV - k));
            end
        end
    endtask

    task automatic test_auto_reload();
        step(1'b1, 1'b0, addr(1, 4'b1000), WIDTH'(1));
        step(1'b1, 1'b0, addr(1, 4'b0100), WIDTH'(2));
        for (int k = 1; k <= 3; k++) begin
            idle();
            checks++;
            if (irq_vec[1] !== (k == 3) || {DO, OE, irq_vec, irq_n} !== exp_out()) begin
                errors++;
                $display("FAIL auto_first k=%0d: got %h irq1=%b want %h", k, {DO, OE, irq_vec, irq_n}, irq_vec[1], exp_out());
            end
        end
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b1, addr(1, 4'b0100), '0);
            checks++;
            if (DO !== WIDTH'(2 - (k % 3)) || {DO, OE, irq_vec, irq_n} !== exp_out()) begin
                errors++;
                $display("FAIL auto_seq k=%0d: got DO=%h want %h", k, DO, WIDTH'(2 - (k % 3)));
            end
        end
    endtask

    task automatic test_read_underflow();
        step(1'b1, 1'b0, addr(1, 4'b1000), WIDTH'(2));
        step(1'b1, 1'b1, addr(1, 4'b0000), '0);
        step(1'b1, 1'b0, addr(0, 4'b0100), WIDTH'(1));
        idle();
        step(1'b1, 1'b1, addr(0, 4'b0100), '0);
        checks++;
        if (DO !== '0 || OE !== 1'b1 || irq_vec[0] !== 1'b1 || irq_n !== 1'b0) begin
            errors++;
            $display("FAIL read_on_underflow: got DO=%h OE=%b irq0=%b irq_n=%b want 00/1/1/0", DO, OE, irq_vec[0], irq_n);
        end
        step(1'b1, 1'b1, addr(0, 4'b0100), '0);
        checks++;
        if (DO !== WIDTH'(MAXV) || irq_vec !== '0 || irq_n !== 1'b1) begin
            errors++;
            $display("FAIL read_clear: got DO=%h irq_vec=%b irq_n=%b want %h/0/1", DO, irq_vec, irq_n, WIDTH'(MAXV));
        end
    endtask

    task automatic test_independent();
        step(1'b1, 1'b0, addr(0, 4'b1000), WIDTH'(1));
        step(1'b1, 1'b0, addr(1, 4'b1000), WIDTH'(1));
        step(1'b1, 1'b0, addr(0, 4'b0111), WIDTH'(1));
        step(1'b1, 1'b0, addr(1, 4'b0100), WIDTH'(3));
        for (int k = 2; k <= 2100; k++) begin
            if (k == 2048 || k == 2049) step(1'b1, 1'b1, addr(0, 4'b0001), '0);
            else if (k % 5 == 0) step(1'b1, 1'b1, addr(1, 4'b0001), '0);
            else idle();
            checks++;
            if ({DO, OE, irq_vec, irq_n} !== exp_out()) begin
                errors++;
                $display("FAIL indep_model k=%0d: got %h want %h", k, {DO, OE, irq_vec, irq_n}, exp_out());
            end
            if (k == 2048 || k == 2049) begin
                checks++;
                if (DO[WIDTH-1] !== (k == 2049)) begin
                    errors++;
                    $display("FAIL indep_ch0_flag k=%0d: got %b want %b", k, DO[WIDTH-1], (k == 2049));
                end
            end
        end
    endtask

    task automatic test_stop();
        step(1'b1, 1'b0, addr(0, 4'b1000), '0);
        step(1'b1, 1'b0, addr(0, 4'b0001), WIDTH'(5));
        for (int k = 1; k <= 20; k++) idle();
        step(1'b1, 1'b0, addr(0, 4'b1000), WIDTH'(2));
        for (int k = 0; k < 50; k++) begin
            step(1'b1, 1'b1, addr(0, 4'b0000), '0);
            checks++;
            if (DO !== WIDTH'(3) || {DO, OE, irq_vec, irq_n} !== exp_out()) begin
                errors++;
                $display("FAIL stop_hold k=%0d: got DO=%h want 03", k, DO);
            end
        end
        step(1'b1, 1'b0, addr(0, 4'b1000), '0);
        for (int k = 1; k <= 26; k++) idle();
        step(1'b1, 1'b1, addr(0, 4'b0001), '0);
        checks++;
        if (DO[WIDTH-1] !== 1'b0) begin
            errors++;
            $display("FAIL stop_resume_early: flag=%b want 0", DO[WIDTH-1]);
        end
        step(1'b1, 1'b1, addr(0, 4'b0001), '0);
        checks++;
        if (DO[WIDTH-1] !== 1'b1 || {DO, OE, irq_vec, irq_n} !== exp_out()) begin
            errors++;
            $display("FAIL stop_resume_fire: flag=%b want 1", DO[WIDTH-1]);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b0, addr(1, 4'b0100), '0);
        idle();
        step(1'b1, 1'b1, addr(1, 4'b0001), '0);
        checks++;
        if (OE !== 1'b1 || irq_vec[1] !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: OE=%b irq1=%b want 1/1", OE, irq_vec[1]);
        end
        rst = 1'b1; cs = 1'b1; we_n = 1'b1; A = addr(1, 4'b0001);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (DO !== '0 || OE !== 1'b0 || irq_vec !== '0 || irq_n !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: got DO=%h OE=%b irq_vec=%b irq_n=%b want 00/0/0/1", DO, OE, irq_vec, irq_n);
        end
        for (int k = 0; k < 20; k++) begin
            idle();
            checks++;
            if ({DO, OE, irq_vec, irq_n} !== exp_out()) begin
                errors++;
                $display("FAIL post_reset k=%0d: got %h want %h", k, {DO, OE, irq_vec, irq_n}, exp_out());
            end
        end
    endtask

    task automatic test_random();
        int r;
        int ch;
        logic [3:0] off;
        logic [WIDTH-1:0] d;
        for (int i = 0; i < 3000; i++) begin
            r   = int'($urandom_range(0, 9));
            ch  = int'($urandom_range(0, CHANNELS - 1));
            off = 4'($urandom_range(0, 15));
            d   = WIDTH'($urandom_range(0, 12));
            if (r < 4) idle();
            else if (r < 6) step(1'b1, 1'b0, addr(ch, {1'b0, off[2:0]}), d);
            else if (r == 6) step(1'b1, 1'b0, addr(ch, off), WIDTH'($urandom_range(0, 3)));
            else step(1'b1, 1'b1, addr(ch, off), d);
            checks++;
            if ({DO, OE, irq_vec, irq_n} !== exp_out()) begin
                errors++;
                $display("FAIL random i=%0d: got %h want %h", i, {DO, OE, irq_vec, irq_n}, exp_out());
            end
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_auto_reload();
        test_read_underflow();
        test_independent();
        test_stop();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
